cnn_layer_accel_result_packer: RTL and testbench

Downstream stage of cnn_layer_accel_quad. It consumes the quad's 16-bit result stream (result_valid/result_accept/result_data) and packs eight results into one 128-bit word for the interface-side writeback path. A per-job result count marks the final, possibly partial, word with last and a lane keep mask. A small output FIFO decouples quad output from writeback backpressure.

---
 rtl/cnn_layer_accel_pkg.sv | 22 ++
 rtl/cnn_layer_accel_fwft_fifo.sv | 54 +++++
 rtl/cnn_layer_accel_result_packer.sv | 152 +++++++++++++++
 tb/tb_cnn_layer_accel_result_packer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_accel_pkg.sv
// Shared types and constants for the CNN layer accelerator result path.
package cnn_layer_accel_pkg;

    localparam int C_RESULT_WIDTH   = 16;
    localparam int C_LANES          = 8;
    localparam int C_OUT_WIDTH      = C_RESULT_WIDTH * C_LANES;
    localparam int C_LANE_IDX_WIDTH = $clog2(C_LANES);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN,
        EMPTY
    } packer_state_t;

    typedef struct packed {
        logic [C_OUT_WIDTH-1:0] data;
        logic [C_LANES-1:0]     keep;
        logic                   last;
    } wb_word_t;

endpackage

// File: rtl/cnn_layer_accel_fwft_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on pop_data whenever not_empty is high.
module cnn_layer_accel_fwft_fifo #(
    parameter int WIDTH = 137,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             not_empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data  = mem[rd_ptr];
    assign not_empty = (count != '0);
    assign full      = (count == DEPTH_CNT);

endmodule

// File: rtl/cnn_layer_accel_result_packer.sv
// Packs the quad's 16-bit result stream into 128-bit writeback words, marking the job's final word.
module cnn_layer_accel_result_packer
    import cnn_layer_accel_pkg::*;
#(
    parameter int C_OUT_FIFO_DEPTH = 2,
    parameter int C_COUNT_WIDTH    = 32
) (
    input  logic                      clk_if,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [C_COUNT_WIDTH-1:0]  cfg_num_results,
    input  logic                      result_valid,
    output logic                      result_accept,
    input  logic [C_RESULT_WIDTH-1:0] result_data,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [C_OUT_WIDTH-1:0]    wb_data,
    output logic [C_LANES-1:0]        wb_keep,
    output logic                      wb_last,
    output logic                      job_done,
    output logic                      err_unexpected
);

    packer_state_t               state;
    packer_state_t               state_next;
    logic [C_COUNT_WIDTH-1:0]    remaining;
    logic [C_LANE_IDX_WIDTH-1:0] lane_idx;
    logic [C_OUT_WIDTH-1:0]      lane_data;
    logic [C_OUT_WIDTH-1:0]      merged_data;
    logic                        err_q;

    logic     cfg_fire;
    logic     accept_fire;
    logic     last_result;
    logic     word_end;
    logic     fifo_push;
    logic     fifo_not_empty;
    logic     fifo_full;
    logic     wb_pop;
    wb_word_t push_word;
    wb_word_t fifo_word;

    assign cfg_fire    = cfg_valid & cfg_ready;
    assign accept_fire = result_valid & result_accept;
    assign last_result = (remaining == C_COUNT_WIDTH'(1));
    assign word_end    = (lane_idx == C_LANE_IDX_WIDTH'(C_LANES - 1)) | last_result;
    assign fifo_push   = accept_fire & word_end;
    assign wb_pop      = wb_valid & wb_ready;

    always_comb begin
        state_next    = state;
        cfg_ready     = 1'b0;
        result_accept = 1'b0;
        job_done      = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    state_next = (cfg_num_results == '0) ? EMPTY : ACTIVE;
                end
            end
            ACTIVE: begin
                result_accept = !fifo_full;
                if (result_valid && !fifo_full && last_result) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (wb_pop && fifo_word.last) begin
                    job_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            EMPTY: begin
                job_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Handshake outputs stay quiet for the whole reset cycle, whatever state we were in.
        if (rst) begin
            cfg_ready     = 1'b0;
            result_accept = 1'b0;
            job_done      = 1'b0;
        end
    end

    // The incoming result is merged combinationally so a completing word is pushed on the same edge.
    always_comb begin
        merged_data = lane_data;
        merged_data[lane_idx*C_RESULT_WIDTH +: C_RESULT_WIDTH] = result_data;
        push_word.data = merged_data;
        push_word.last = last_result;
        for (int i = 0; i < C_LANES; i++) begin
            push_word.keep[i] = (i <= int'(lane_idx));
        end
    end

    always_ff @(posedge clk_if) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            lane_idx  <= '0;
            lane_data <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            if (cfg_fire) begin
                remaining <= cfg_num_results;
                lane_idx  <= '0;
                lane_data <= '0;
                err_q     <= 1'b0;
            end
            if (accept_fire) begin
                remaining <= remaining - 1'b1;
                if (word_end) begin
                    lane_idx  <= '0;
                    lane_data <= '0;
                end else begin
                    lane_idx  <= lane_idx + 1'b1;
                    lane_data <= merged_data;
                end
            end
            if (result_valid && state != ACTIVE) begin
                err_q <= 1'b1;
            end
        end
    end

    cnn_layer_accel_fwft_fifo #(
        .WIDTH ($bits(wb_word_t)),
        .DEPTH (C_OUT_FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk_if),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_word),
        .pop       (wb_pop),
        .pop_data  (fifo_word),
        .not_empty (fifo_not_empty),
        .full      (fifo_full)
    );

    // Word fields are zeroed whenever no word is offered so stale FIFO entries never leak out.
    assign wb_valid       = fifo_not_empty & !rst;
    assign wb_data        = wb_valid ? fifo_word.data : '0;
    assign wb_keep        = wb_valid ? fifo_word.keep : '0;
    assign wb_last        = wb_valid ? fifo_word.last : 1'b0;
    assign err_unexpected = err_q & !rst;

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// Directed scoreboard bench for cnn_layer_accel_result_packer.
module tb_cnn_layer_accel_result_packer;

    logic         clk_if = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [31:0]  cfg_num_results;
    logic         result_valid;
    logic         result_accept;
    logic [15:0]  result_data;
    logic         wb_valid;
    logic         wb_ready;
    logic [127:0] wb_data;
    logic [7:0]   wb_keep;
    logic         wb_last;
    logic         job_done;
    logic         err_unexpected;

    int n_asserts = 0;
    int n_fails   = 0;
    int job_done_count = 0;
    int wb_word_count  = 0;

    logic [127:0] exp_data [$];
    logic [7:0]   exp_keep [$];
    logic         exp_last [$];

    cnn_layer_accel_result_packer dut (
        .clk_if          (clk_if),
        .rst             (rst),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_num_results (cfg_num_results),
        .result_valid    (result_valid),
        .result_accept   (result_accept),
        .result_data     (result_data),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_data         (wb_data),
        .wb_keep         (wb_keep),
        .wb_last         (wb_last),
        .job_done        (job_done),
        .err_unexpected  (err_unexpected)
    );

    always #5 clk_if = ~clk_if;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic reportTimeout(input string tag);
        n_asserts++;
        n_fails++;
        $error("[TB] FAIL %s: observed timeout expected completion", tag);
    endtask

    // Configure a job; when wanted, push the words it should produce onto the scoreboard.
    task automatic applyStimulus(input int num, input logic [15:0] base, input bit expect_words);
        logic [127:0] d;
        int lane;
        int waited;
        bit got;
        if (expect_words) begin
            d = '0;
            lane = 0;
            for (int i = 0; i < num; i++) begin
                d[lane*16 +: 16] = base + 16'(i);
                lane++;
                if (lane == 8 || i == num - 1) begin
                    exp_data.push_back(d);
                    exp_keep.push_back(8'((1 << lane) - 1));
                    exp_last.push_back(i == num - 1);
                    d = '0;
                    lane = 0;
                end
            end
        end
        cfg_valid = 1'b1;
        cfg_num_results = 32'(num);
        got = 1'b0;
        waited = 0;
        while (!got && waited < 100) begin
            @(negedge clk_if);
            if (cfg_ready) got = 1'b1;
            else waited++;
        end
        if (!got) reportTimeout("cfg_handshake");
        @(posedge clk_if);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic sendResult(input logic [15:0] d);
        int waited;
        bit got;
        result_valid = 1'b1;
        result_data = d;
        got = 1'b0;
        waited = 0;
        while (!got && waited < 100) begin
            @(negedge clk_if);
            if (result_accept) got = 1'b1;
            else waited++;
        end
        if (!got) reportTimeout("result_accept");
        @(posedge clk_if);
        #1;
        result_valid = 1'b0;
    endtask

    task automatic waitJobDone(input int target, input string tag);
        int waited;
        waited = 0;
        while (job_done_count < target && waited < 100) begin
            @(negedge clk_if);
            waited++;
        end
        if (job_done_count < target) reportTimeout(tag);
        repeat (3) @(negedge clk_if);
        checkOutput({tag, "_count"}, 128'(job_done_count), 128'(target));
        checkOutput({tag, "_sb_empty"}, 128'(exp_data.size()), 128'd0);
        @(posedge clk_if);
        #1;
    endtask

    // Scoreboard side: compare every accepted writeback word against the queue head.
    always @(negedge clk_if) begin
        if (job_done) job_done_count++;
        if (wb_valid && wb_ready) begin
            wb_word_count++;
            if (exp_data.size() == 0) begin
                reportTimeout("unexpected_wb_word");
            end else begin
                checkOutput("wb_data", wb_data, exp_data.pop_front());
                checkOutput("wb_keep", 128'(wb_keep), 128'(exp_keep.pop_front()));
                checkOutput("wb_last", 128'(wb_last), 128'(exp_last.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int jd;
        int wc;
        logic [127:0] word0;

        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_num_results = '0;
        result_valid = 1'b0;
        result_data = '0;
        wb_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk_if);
        @(negedge clk_if);
        checkOutput("rst_cfg_ready", 128'(cfg_ready), 128'd0);
        checkOutput("rst_result_accept", 128'(result_accept), 128'd0);
        checkOutput("rst_wb_valid", 128'(wb_valid), 128'd0);
        checkOutput("rst_wb_data", wb_data, 128'd0);
        checkOutput("rst_wb_keep", 128'(wb_keep), 128'd0);
        checkOutput("rst_wb_last", 128'(wb_last), 128'd0);
        checkOutput("rst_job_done", 128'(job_done), 128'd0);
        checkOutput("rst_err", 128'(err_unexpected), 128'd0);
        @(posedge clk_if);
        #1;
        rst = 1'b0;
        @(negedge clk_if);
        checkOutput("post_rst_cfg_ready", 128'(cfg_ready), 128'd1);
        @(posedge clk_if);
        #1;

        // Two full words
        $display("[TB] job of 16 results");
        jd = job_done_count;
        applyStimulus(16, 16'h0000, 1'b1);
        for (int i = 0; i < 16; i++) sendResult(16'(i));
        @(negedge clk_if);
        checkOutput("t1_latency_valid", 128'(wb_valid), 128'd1);
        checkOutput("t1_latency_last", 128'(wb_last), 128'd1);
        waitJobDone(jd + 1, "t1_job_done");

        // Partial final word
        $display("[TB] job of 10 results");
        jd = job_done_count;
        applyStimulus(10, 16'h0100, 1'b1);
        for (int i = 0; i < 10; i++) sendResult(16'h0100 + 16'(i));
        waitJobDone(jd + 1, "t2_job_done");

        // Backpressure fills the output FIFO
        $display("[TB] job of 24 results under backpressure");
        jd = job_done_count;
        wb_ready = 1'b0;
        word0 = '0;
        for (int i = 0; i < 8; i++) word0[i*16 +: 16] = 16'h0200 + 16'(i);
        applyStimulus(24, 16'h0200, 1'b1);
        for (int i = 0; i < 16; i++) sendResult(16'h0200 + 16'(i));
        result_valid = 1'b1;
        result_data = 16'h0210;
        @(negedge clk_if);
        checkOutput("t3_accept_full", 128'(result_accept), 128'd0);
        checkOutput("t3_wb_valid_stall", 128'(wb_valid), 128'd1);
        checkOutput("t3_wb_keep_stall", 128'(wb_keep), 128'hFF);
        checkOutput("t3_wb_last_stall", 128'(wb_last), 128'd0);
        @(negedge clk_if);
        checkOutput("t3_accept_still_full", 128'(result_accept), 128'd0);
        checkOutput("t3_wb_data_hold", wb_data, word0);
        @(posedge clk_if);
        #1;
        wb_ready = 1'b1;
        for (int i = 16; i < 24; i++) sendResult(16'h0200 + 16'(i));
        waitJobDone(jd + 1, "t3_job_done");

        // Empty job
        $display("[TB] empty job");
        jd = job_done_count;
        wc = wb_word_count;
        applyStimulus(0, 16'h0000, 1'b1);
        @(negedge clk_if);
        checkOutput("t4_job_done_pulse", 128'(job_done), 128'd1);
        checkOutput("t4_wb_valid", 128'(wb_valid), 128'd0);
        @(posedge clk_if);
        #1;
        @(negedge clk_if);
        checkOutput("t4_job_done_drop", 128'(job_done), 128'd0);
        checkOutput("t4_cfg_ready", 128'(cfg_ready), 128'd1);
        checkOutput("t4_no_words", 128'(wb_word_count - wc), 128'd0);
        checkOutput("t4_done_count", 128'(job_done_count - jd), 128'd1);
        @(posedge clk_if);
        #1;

        // Unexpected result while idle
        $display("[TB] result while idle");
        wc = wb_word_count;
        result_valid = 1'b1;
        result_data = 16'h0055;
        @(negedge clk_if);
        checkOutput("t5_accept_idle", 128'(result_accept), 128'd0);
        @(posedge clk_if);
        #1;
        result_valid = 1'b0;
        @(negedge clk_if);
        checkOutput("t5_err_set", 128'(err_unexpected), 128'd1);
        checkOutput("t5_wb_valid", 128'(wb_valid), 128'd0);
        @(posedge clk_if);
        #1;

        // Reset mid-job, then a clean job of 8
        $display("[TB] reset mid-job");
        applyStimulus(16, 16'h0300, 1'b0);
        @(negedge clk_if);
        checkOutput("t5_err_cleared", 128'(err_unexpected), 128'd0);
        @(posedge clk_if);
        #1;
        for (int i = 0; i < 5; i++) sendResult(16'h0300 + 16'(i));
        rst = 1'b1;
        @(negedge clk_if);
        checkOutput("t6_rst_cfg_ready", 128'(cfg_ready), 128'd0);
        checkOutput("t6_rst_accept", 128'(result_accept), 128'd0);
        @(posedge clk_if);
        #1;
        rst = 1'b0;
        @(negedge clk_if);
        checkOutput("t6_cfg_ready", 128'(cfg_ready), 128'd1);
        checkOutput("t6_wb_valid", 128'(wb_valid), 128'd0);
        checkOutput("t6_wb_data", wb_data, 128'd0);
        checkOutput("t6_err", 128'(err_unexpected), 128'd0);
        @(posedge clk_if);
        #1;
        jd = job_done_count;
        wc = wb_word_count;
        applyStimulus(8, 16'h0400, 1'b1);
        for (int i = 0; i < 8; i++) sendResult(16'h0400 + 16'(i));
        waitJobDone(jd + 1, "t6_job_done");
        checkOutput("t6_one_word", 128'(wb_word_count - wc), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
